// File: rtl/ex_div_seq.sv
// ex_div_seq: iterative RV32M DIV/DIVU/REM/REMU sequencer beside the execute stage
module ex_div_seq #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [1:0]            op_i,
    input  logic [DATA_WIDTH-1:0] rs1_data_i,
    input  logic [DATA_WIDTH-1:0] rs2_data_i,
    input  logic                  flush_i,
    output logic                  stall_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] result_o
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t        state, state_n;
    logic [CW-1:0] count;
    logic          sel_rem, neg_q, neg_r;
    logic [W-1:0]  quo, rem, dvs;
    logic          go, sgn, div_zero, ovf, fast;
    logic [W-1:0]  a_abs, b_abs, fast_res, fix_res;
    logic [W:0]    trial;

    // operand preparation, fast-path detection and the per-iteration trial subtract
    always_comb begin
        go       = (state == IDLE) && start_i && !flush_i;
        sgn      = !op_i[0];
        div_zero = (rs2_data_i == '0);
        ovf      = sgn && (rs1_data_i == {1'b1, {(W-1){1'b0}}}) && (&rs2_data_i);
        fast     = div_zero || ovf;
        a_abs    = (sgn && rs1_data_i[W-1]) ? -rs1_data_i : rs1_data_i;
        b_abs    = (sgn && rs2_data_i[W-1]) ? -rs2_data_i : rs2_data_i;
        fast_res = div_zero ? (op_i[1] ? rs1_data_i : '1) : (op_i[1] ? '0 : rs1_data_i);
        trial    = {rem, quo[W-1]} - {1'b0, dvs};
        fix_res  = sel_rem ? (neg_r ? -rem : rem) : (neg_q ? -quo : quo);
    end

    // next-state and stall; flush wins in every state
    always_comb begin
        state_n = state;
        stall_o = go || (state == CALC) || (state == FIX);
        if (flush_i) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE:    state_n = start_i ? (fast ? DONE : CALC) : IDLE;
                CALC:    state_n = (count == '0) ? FIX : CALC;
                FIX:     state_n = DONE;
                default: state_n = IDLE;
            endcase
        end
    end

    assign busy_o = (state != IDLE);

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // datapath: latch operands, iterate restoring division, load result on FIX or fast path
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            sel_rem  <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            quo      <= '0;
            rem      <= '0;
            dvs      <= '0;
            result_o <= '0;
            done_o   <= 1'b0;
        end else begin
            done_o <= (state_n == DONE);
            if (go) begin
                sel_rem <= op_i[1];
                neg_q   <= sgn && (rs1_data_i[W-1] ^ rs2_data_i[W-1]);
                neg_r   <= sgn && rs1_data_i[W-1];
                quo     <= a_abs;
                rem     <= '0;
                dvs     <= b_abs;
                count   <= CW'(W - 1);
                if (fast) result_o <= fast_res;
            end else if (state == CALC && !flush_i) begin
                count <= count - 1'b1;
                rem   <= trial[W] ? {rem[W-2:0], quo[W-1]} : trial[W-1:0];
                quo   <= {quo[W-2:0], !trial[W]};
            end else if (state == FIX && !flush_i) begin
                result_o <= fix_res;
            end
        end
    end
endmodule

// File: doc/ex_div_seq.md
# ex_div_seq

Iterative RV32M divide/remainder sequencer that sits beside the execute stage and shares its forwarded operand path. When EX holds a DIV/DIVU/REM/REMU instruction, this block freezes the front of the pipeline, runs a radix-2 restoring division over DATA_WIDTH cycles, and presents the result for one cycle. The EX stage captures that result into its ALU-result pipeline register in place of the ALU output. Divide-by-zero and signed overflow take a single-cycle fast path.

## Interface
- DATA_WIDTH, 32, operand/result width
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- start_i  in  1  EX holds a valid divide-class instruction
- op_i  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU; sampled with start_i
- rs1_data_i  in  DATA_WIDTH  dividend, after forwarding mux
- rs2_data_i  in  DATA_WIDTH  divisor, after forwarding mux
- flush_i  in  1  pipeline flush; aborts any operation
- stall_o  out  1  freeze PC, IF/ID and ID/EX registers
- busy_o  out  1  state is not IDLE
- done_o  out  1  one-cycle pulse; result_o valid
- result_o  out  DATA_WIDTH  quotient or remainder

## Operation
- FSM states:
  - IDLE: waits for start.
  - CALC: runs the DATA_WIDTH iterations.
  - FIX: applies sign correction.
  - DONE: presents the result.
- IDLE, start_i=1, flush_i=0:
  - Latch op_i and the operands.
  - If the divisor is 0 or the op is signed overflow, go to DONE (fast path); otherwise go to CALC with count=DATA_WIDTH-1.
- Operand preparation: signed ops (DIV, REM) divide the absolute values; unsigned ops use the raw values. Record neg_q = sign(rs1)^sign(rs2) and neg_r = sign(rs1).
- CALC, once per cycle:
  - Shift {rem, quo} left by 1.
  - Trial-subtract the divisor from the upper DATA_WIDTH+1 bits. If the difference is non-negative, keep it and set the quo LSB to 1.
  - Decrement count. At count==0, go to FIX.
- FIX:
  - Negate quo if neg_q; negate rem if neg_r (signed ops only).
  - Select quo for DIV/DIVU and rem for REM/REMU into result_o. Go to DONE.
- Fast-path results:
  - Divisor 0: DIV/DIVU give all-ones; REM/REMU give the dividend.
  - DIV of 0x8000_0000 by 0xFFFF_FFFF gives 0x8000_0000; REM gives 0.
- DONE: done_o=1, stall_o=0. The pipeline advances. start_i is ignored in DONE (it is the same instruction). Next state is IDLE.
- stall_o = (IDLE & start_i & ~flush_i) | CALC | FIX. It is combinational on start_i so that EX operands are held from the first cycle.
- flush_i has priority in every state: next state IDLE, done_o stays 0, result_o is unchanged. flush_i together with start_i in IDLE means no start.
- Asynchronous reset, any state: state=IDLE, count=0, internal registers=0, result_o=0, done_o=0, busy_o=0. With start_i low, stall_o=0.
- result_o holds its last value until the next FIX or fast-path load.

## Timing
- Normal path, with cycle 0 = start_i sampled in IDLE:
  - Cycles 1..DATA_WIDTH: CALC.
  - Cycle DATA_WIDTH+1: FIX.
  - Cycle DATA_WIDTH+2: DONE. That is 34 cycles with the default width.
  - stall_o is high in cycles 0..DATA_WIDTH+1 (34 cycles) and low in DONE.
- Fast path: cycle 0 start, cycle 1 DONE. stall_o is high for cycle 0 only.
- Back-to-back divides: the earliest next start is the cycle after DONE (IDLE).
- done_o and result_o are registered outputs; stall_o is the only combinational output.
- busy_o is high from cycle 1 through DONE inclusive.

## Test plan
- DIVU 100/7 with start at cycle 0 -> stall_o high cycles 0-33; done_o at cycle 34 with result_o=14. Then REMU 100/7 -> 2.
- DIV -7/2 -> 0xFFFF_FFFD (-3). REM -7/2 -> 0xFFFF_FFFF (-1). REM 7/-2 -> 1.
- DIV 5/0 -> done_o at cycle 1, result_o=0xFFFF_FFFF. REMU 5/0 -> 5.
- DIV 0x8000_0000/0xFFFF_FFFF -> done_o at cycle 1, result_o=0x8000_0000. REM of the same operands -> 0.
- DIVU started, flush_i at cycle 10 -> IDLE at cycle 11, no done_o, stall_o=0, result_o unchanged. A new DIVU 9/3 at cycle 12 -> done_o at cycle 46 with result_o=3.
- rst_n low mid-CALC (cycle 15) -> all outputs return to reset values immediately. start_i held high through DONE does not retrigger; done_o is exactly one pulse.
